// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue
//   Small in-order queue that buffers execution results (one or two register
//   writes per entry) and drains them, one entry per cycle, into registered
//   register-file write ports. A combinational bypass lookup reports the
//   youngest pending value for a register index.
//
//   Optional feature macro: WBQ_LOOKUP_EN
//     defined   -> bypass lookup logic is built
//     undefined -> lookup_hit / lookup_data are tied to 0 (ports remain)
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   flush                    synchronous discard of queued and staged writes
//   drain_en                 allow one dequeue per cycle
//   in_valid / in_ready      result handshake
//   in_reg1/2, in_data1/2    destination indices and data; in_dual = 2nd write
//   out_we, out_we2          write enables (registered)
//   out_reg1/2, out_data1/2  write port drive (registered)
//   count                    current occupancy
//   lookup_reg / lookup_hit / lookup_data   pending-write bypass query

module reg_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 16,
    parameter int AW    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     drain_en,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_reg1,
    input  logic [AW-1:0]            in_reg2,
    input  logic [DW-1:0]            in_data1,
    input  logic [DW-1:0]            in_data2,
    input  logic                     in_dual,
    output logic                     out_we,
    output logic                     out_we2,
    output logic [AW-1:0]            out_reg1,
    output logic [AW-1:0]            out_reg2,
    output logic [DW-1:0]            out_data1,
    output logic [DW-1:0]            out_data2,
    output logic [$clog2(DEPTH):0]   count,
    input  logic [AW-1:0]            lookup_reg,
    output logic                     lookup_hit,
    output logic [DW-1:0]            lookup_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] reg1_mem  [DEPTH];
    logic [DW-1:0] data1_mem [DEPTH];
    logic          dual_mem  [DEPTH];
    logic [AW-1:0] reg2_mem  [DEPTH];
    logic [DW-1:0] data2_mem [DEPTH];

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          out_we_q, out_we_d, out_we2_q, out_we2_d;
    logic [AW-1:0] out_reg1_q, out_reg1_d, out_reg2_q, out_reg2_d;
    logic [DW-1:0] out_data1_q, out_data1_d, out_data2_q, out_data2_d;

    logic          enq, deq, same_reg, ent_dual;
    logic [DW-1:0] ent_data1;

    // A dual write to the same register collapses to one write of the
    // second result, so the register file never sees two writes to one index.
    always_comb begin
        same_reg  = in_dual && (in_reg1 == in_reg2);
        ent_dual  = in_dual && !same_reg;
        ent_data1 = same_reg ? in_data2 : in_data1;
    end

    assign in_ready = (count_q < CW'(DEPTH));

    always_comb begin
        enq         = in_valid && in_ready && !flush;
        deq         = drain_en && (count_q != '0) && !flush;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        out_we_d    = 1'b0;
        out_we2_d   = 1'b0;
        out_reg1_d  = out_reg1_q;
        out_reg2_d  = out_reg2_q;
        out_data1_d = out_data1_q;
        out_data2_d = out_data2_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                tail_d = tail_q + PW'(1);
            end
            if (deq) begin
                head_d      = head_q + PW'(1);
                out_we_d    = 1'b1;
                out_we2_d   = dual_mem[head_q];
                out_reg1_d  = reg1_mem[head_q];
                out_reg2_d  = reg2_mem[head_q];
                out_data1_d = data1_mem[head_q];
                out_data2_d = data2_mem[head_q];
            end
            if (enq && !deq) begin
                count_d = count_q + CW'(1);
            end else if (!enq && deq) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            out_we_q    <= 1'b0;
            out_we2_q   <= 1'b0;
            out_reg1_q  <= '0;
            out_reg2_q  <= '0;
            out_data1_q <= '0;
            out_data2_q <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            out_we_q    <= out_we_d;
            out_we2_q   <= out_we2_d;
            out_reg1_q  <= out_reg1_d;
            out_reg2_q  <= out_reg2_d;
            out_data1_q <= out_data1_d;
            out_data2_q <= out_data2_d;
        end
    end

    // Entry storage is not reset; validity is tracked by head/count only.
    always_ff @(posedge clk) begin
        if (enq) begin
            reg1_mem[tail_q]  <= in_reg1;
            data1_mem[tail_q] <= ent_data1;
            dual_mem[tail_q]  <= ent_dual;
            reg2_mem[tail_q]  <= in_reg2;
            data2_mem[tail_q] <= in_data2;
        end
    end

    assign out_we    = out_we_q;
    assign out_we2   = out_we2_q;
    assign out_reg1  = out_reg1_q;
    assign out_reg2  = out_reg2_q;
    assign out_data1 = out_data1_q;
    assign out_data2 = out_data2_q;
    assign count     = count_q;

`ifdef WBQ_LOOKUP_EN
    // Walk entries oldest to youngest; later matches overwrite earlier ones,
    // so the youngest entry wins. Within an entry reg2 is checked first
    // because it is the later of the two writes.
    always_comb begin
        logic [PW-1:0] idx;
        idx         = '0;
        lookup_hit  = 1'b0;
        lookup_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                if (dual_mem[idx] && (reg2_mem[idx] == lookup_reg)) begin
                    lookup_hit  = 1'b1;
                    lookup_data = data2_mem[idx];
                end else if (reg1_mem[idx] == lookup_reg) begin
                    lookup_hit  = 1'b1;
                    lookup_data = data1_mem[idx];
                end
            end
        end
    end
`else
    logic unused_lookup;
    assign unused_lookup = ^lookup_reg;
    assign lookup_hit    = 1'b0;
    assign lookup_data   = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
module tb_reg_writeback_queue;

    localparam int DEPTH = 4;
`ifdef WBQ_LOOKUP_EN
    localparam bit LK_EN = 1'b1;
`else
    localparam bit LK_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  r1;
        logic [15:0] d1;
        logic        we2;
        logic [3:0]  r2;
        logic [15:0] d2;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0, drain_en = 1'b0, in_valid = 1'b0, in_dual = 1'b0;
    logic        in_ready;
    logic [3:0]  in_reg1 = '0, in_reg2 = '0, lookup_reg = '0;
    logic [15:0] in_data1 = '0, in_data2 = '0;
    logic        out_we, out_we2, lookup_hit;
    logic [3:0]  out_reg1, out_reg2;
    logic [15:0] out_data1, out_data2, lookup_data;
    logic [2:0]  count;

    int  n_cmp = 0;
    int  n_err = 0;
    int  m_cnt = 0;
    wr_t sb[$];

    reg_writeback_queue #(.DEPTH(DEPTH), .DW(16), .AW(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .drain_en(drain_en),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_reg1(in_reg1), .in_reg2(in_reg2),
        .in_data1(in_data1), .in_data2(in_data2), .in_dual(in_dual),
        .out_we(out_we), .out_we2(out_we2),
        .out_reg1(out_reg1), .out_reg2(out_reg2),
        .out_data1(out_data1), .out_data2(out_data2),
        .count(count), .lookup_reg(lookup_reg),
        .lookup_hit(lookup_hit), .lookup_data(lookup_data)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every emitted write must match the oldest expected one.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (out_we2 === 1'b1 && out_we !== 1'b1) begin
                n_cmp++; n_err++;
                $display("FAIL we2_without_we: out_we=%b out_we2=%b", out_we, out_we2);
            end
            if (out_we === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write: got reg1=%0d data1=%h, required no write", out_reg1, out_data1);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    if (out_reg1 !== e.r1 || out_data1 !== e.d1 || out_we2 !== e.we2 ||
                        (e.we2 && (out_reg2 !== e.r2 || out_data2 !== e.d2))) begin
                        n_err++;
                        $display("FAIL write_order: got %0d/%h we2=%b %0d/%h, required %0d/%h we2=%b %0d/%h",
                                 out_reg1, out_data1, out_we2, out_reg2, out_data2,
                                 e.r1, e.d1, e.we2, e.r2, e.d2);
                    end
                end
            end
        end
    end

    // Drives one cycle of stimulus and advances the reference occupancy model.
    task automatic step(input logic v, input logic [3:0] r1, input logic [15:0] d1,
                        input logic du, input logic [3:0] r2, input logic [15:0] d2,
                        input logic dr, input logic fl);
        bit acc, deq;
        wr_t e;
        in_valid = v; in_reg1 = r1; in_data1 = d1; in_dual = du;
        in_reg2 = r2; in_data2 = d2; drain_en = dr; flush = fl;
        acc = v && !fl && (m_cnt < DEPTH);
        deq = dr && (m_cnt > 0) && !fl;
        if (fl) sb.delete();
        if (acc) begin
            if (du && r1 == r2) e = '{r1: r1, d1: d2, we2: 1'b0, r2: r2, d2: d2};
            else                e = '{r1: r1, d1: d1, we2: du, r2: r2, d2: d2};
            sb.push_back(e);
        end
        @(posedge clk);
        if (fl) m_cnt = 0;
        else    m_cnt = m_cnt + (acc ? 1 : 0) - (deq ? 1 : 0);
        #1;
        in_valid = 1'b0; flush = 1'b0; in_dual = 1'b0;
    endtask

    task automatic idle(input logic dr);
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, dr, 1'b0);
    endtask

    task automatic test_reset;
        #2;
        n_cmp++; if (count !== 3'd0)     begin n_err++; $display("FAIL reset_count: got %0d, required 0", count); end
        n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_ready: got %b, required 1", in_ready); end
        n_cmp++; if (out_we !== 1'b0 || out_we2 !== 1'b0 || out_reg1 !== 4'd0 || out_data1 !== 16'h0)
            begin n_err++; $display("FAIL reset_outs: got we=%b we2=%b reg1=%0d data1=%h, required all 0", out_we, out_we2, out_reg1, out_data1); end
        #5 rst = 1'b1;
    endtask

    task automatic test_single;
        step(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
        n_cmp++; if (out_we !== 1'b0 || count !== 3'd1)
            begin n_err++; $display("FAIL single_no_passthru: got we=%b count=%0d, required we=0 count=1", out_we, count); end
        idle(1'b1);
        n_cmp++; if (out_we !== 1'b1 || out_reg1 !== 4'd3 || out_data1 !== 16'h1234 || count !== 3'd0)
            begin n_err++; $display("FAIL single_write: got we=%b reg1=%0d data1=%h count=%0d, required 1/3/1234/0", out_we, out_reg1, out_data1, count); end
    endtask

    task automatic test_full;
        for (int i = 0; i < 5; i++)
            step(1'b1, 4'(i + 1), 16'(16'h0100 + i), 1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
        n_cmp++; if (count !== 3'd4 || in_ready !== 1'b0)
            begin n_err++; $display("FAIL full_state: got count=%0d ready=%b, required 4/0", count, in_ready); end
        // full with a simultaneous dequeue: the offered entry must be refused
        step(1'b1, 4'hF, 16'hDEAD, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
        n_cmp++; if (count !== 3'd3 || in_ready !== 1'b1 || out_reg1 !== 4'd1)
            begin n_err++; $display("FAIL full_first_drain: got count=%0d ready=%b reg1=%0d, required 3/1/1", count, in_ready, out_reg1); end
        for (int i = 0; i < 3; i++) idle(1'b1);
        idle(1'b0);
        n_cmp++; if (count !== 3'd0 || out_we !== 1'b0)
            begin n_err++; $display("FAIL full_drained: got count=%0d we=%b, required 0/0", count, out_we); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 4'(i + 8), 16'(16'h0200 + 3 * i), 1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
            n_cmp++; if (count !== 3'd1)
                begin n_err++; $display("FAIL b2b_count_%0d: got %0d, required 1", i, count); end
        end
        idle(1'b1);
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL b2b_final_count: got %0d, required 0", count); end
    endtask

    task automatic test_dual;
        step(1'b1, 4'd2, 16'hAAAA, 1'b1, 4'd9, 16'h5555, 1'b1, 1'b0);
        idle(1'b1);
        n_cmp++; if (out_we !== 1'b1 || out_we2 !== 1'b1 || out_reg1 !== 4'd2 || out_reg2 !== 4'd9 || out_data2 !== 16'h5555)
            begin n_err++; $display("FAIL dual_write: got we=%b we2=%b reg1=%0d reg2=%0d data2=%h, required 1/1/2/9/5555", out_we, out_we2, out_reg1, out_reg2, out_data2); end
        step(1'b1, 4'd4, 16'h1111, 1'b1, 4'd4, 16'h2222, 1'b1, 1'b0);
        idle(1'b1);
        n_cmp++; if (out_we !== 1'b1 || out_we2 !== 1'b0 || out_reg1 !== 4'd4 || out_data1 !== 16'h2222)
            begin n_err++; $display("FAIL dual_collapse: got we=%b we2=%b reg1=%0d data1=%h, required 1/0/4/2222", out_we, out_we2, out_reg1, out_data1); end
        idle(1'b0);
        n_cmp++; if (out_we !== 1'b0 || out_data1 !== 16'h2222)
            begin n_err++; $display("FAIL out_hold: got we=%b data1=%h, required 0/2222", out_we, out_data1); end
    endtask

    task automatic test_lookup;
        drain_en = 1'b0; lookup_reg = 4'd7; #1;
        n_cmp++; if (lookup_hit !== 1'b0 || lookup_data !== 16'h0)
            begin n_err++; $display("FAIL lookup_empty: got %b/%h, required 0/0000", lookup_hit, lookup_data); end
        step(1'b1, 4'd7, 16'h0001, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
        step(1'b1, 4'd7, 16'h0002, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
        step(1'b1, 4'd5, 16'h000B, 1'b1, 4'd6, 16'h000C, 1'b0, 1'b0);
        lookup_reg = 4'd7; #1;
        n_cmp++; if (lookup_hit !== LK_EN || lookup_data !== (LK_EN ? 16'h0002 : 16'h0))
            begin n_err++; $display("FAIL lookup_youngest: got %b/%h, required %b/%h", lookup_hit, lookup_data, LK_EN, LK_EN ? 16'h0002 : 16'h0); end
        lookup_reg = 4'd6; #1;
        n_cmp++; if (lookup_hit !== LK_EN || lookup_data !== (LK_EN ? 16'h000C : 16'h0))
            begin n_err++; $display("FAIL lookup_reg2: got %b/%h, required %b/%h", lookup_hit, lookup_data, LK_EN, LK_EN ? 16'h000C : 16'h0); end
        lookup_reg = 4'd5; #1;
        n_cmp++; if (lookup_hit !== LK_EN || lookup_data !== (LK_EN ? 16'h000B : 16'h0))
            begin n_err++; $display("FAIL lookup_reg1: got %b/%h, required %b/%h", lookup_hit, lookup_data, LK_EN, LK_EN ? 16'h000B : 16'h0); end
        lookup_reg = 4'd8; #1;
        n_cmp++; if (lookup_hit !== 1'b0 || lookup_data !== 16'h0)
            begin n_err++; $display("FAIL lookup_miss: got %b/%h, required 0/0000", lookup_hit, lookup_data); end
    endtask

    task automatic test_flush;
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL flush_pre_count: got %0d, required 3", count); end
        step(1'b1, 4'd1, 16'h0077, 1'b0, 4'd0, 16'h0, 1'b1, 1'b1);
        n_cmp++; if (count !== 3'd0 || out_we !== 1'b0 || in_ready !== 1'b1)
            begin n_err++; $display("FAIL flush_state: got count=%0d we=%b ready=%b, required 0/0/1", count, out_we, in_ready); end
        lookup_reg = 4'd7; #1;
        n_cmp++; if (lookup_hit !== 1'b0) begin n_err++; $display("FAIL flush_lookup: got hit=%b, required 0", lookup_hit); end
        for (int i = 0; i < 3; i++) idle(1'b1);
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_post_count: got %0d, required 0", count); end
    endtask

    task automatic test_reset_mid;
        step(1'b1, 4'd10, 16'h0A0A, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
        step(1'b1, 4'd11, 16'h0B0B, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
        step(1'b1, 4'd12, 16'h0C0C, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
        #2;
        n_cmp++; if (out_we !== 1'b1 || count !== 3'd2)
            begin n_err++; $display("FAIL premid_state: got we=%b count=%0d, required 1/2", out_we, count); end
        rst = 1'b0;
        #1;
        n_cmp++; if (out_we !== 1'b0 || out_reg1 !== 4'd0 || out_data1 !== 16'h0 || count !== 3'd0)
            begin n_err++; $display("FAIL async_reset: got we=%b reg1=%0d data1=%h count=%0d, required all 0", out_we, out_reg1, out_data1, count); end
        sb.delete();
        m_cnt = 0;
        @(negedge clk);
        #2 rst = 1'b1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_reset: got %b, required 1", in_ready); end
        for (int i = 0; i < 4; i++) idle(1'b1);
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL post_reset_count: got %0d, required 0", count); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_full;
        test_back_to_back;
        test_dual;
        test_lookup;
        test_flush;
        test_reset_mid;
        idle(1'b1);
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL pending_expected: got %0d outstanding, required 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
